// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, oversampled 3-sample majority vote, parity/framing/overrun flags.
// Latency: word presented the cycle after the last stop bit's mid-bit decision tick (~3 clk sync + frame).
// Backpressure: valid/ready hold; a word completing while the previous one is still unaccepted is dropped with an overrun pulse.
//
// Ports:
//   clk_i, reset_i (async, active-high)   rx_i   serial line, idle high, asynchronous
//   data_o/valid_o/ready_i                received word stream, LSB = first data bit
//   parity_err_o, frame_err_o             qualify data_o while valid_o=1
//   overrun_o                             one-cycle pulse when a completed word is dropped
//   busy_o                                receiver is inside a frame
module uart_rx_param #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int DIV   = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);
  localparam int M     = OVERSAMPLE / 2;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } state_t;

  state_t state, state_next;

  logic                 sync_q, rx_s, rx_prev;
  logic [DIV_W-1:0]     div_cnt;
  logic [SMP_W-1:0]     smp_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 vote_a, vote_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q, frm_q;

  logic start_edge, tick, decide, bit_end, bit_val;
  logic last_data, last_stop, complete, par_exp;

  // Synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q  <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= rx_i;
      rx_s    <= sync_q;
      rx_prev <= rx_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start_edge) state_next = ST_START;
      ST_START: begin
        if (decide && bit_val) state_next = ST_IDLE;      // false start
        else if (bit_end)      state_next = ST_DATA;
      end
      ST_DATA:   if (bit_end && last_data)
                   state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      // Leave at mid-bit of the last stop bit so a following start edge is caught.
      ST_STOP:   if (complete) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output / decode logic.
  always_comb begin
    start_edge = rx_prev & ~rx_s;
    tick       = (state != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));
    decide     = tick && (smp_cnt == SMP_W'(M + 1));
    bit_end    = tick && (smp_cnt == SMP_W'(OVERSAMPLE - 1));
    // Third vote is the live sample at the decision index.
    bit_val    = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    last_data  = (bit_cnt == CNT_W'(DATA_BITS - 1));
    last_stop  = (bit_cnt == CNT_W'(STOP_BITS - 1));
    complete   = (state == ST_STOP) && decide && last_stop;
    par_exp    = (^shreg) ^ (PARITY == 1);
    busy_o     = (state != ST_IDLE);
  end

  // Datapath: counters, shift register, error accumulation, output stage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt      <= '0;
      smp_cnt      <= '0;
      bit_cnt      <= '0;
      vote_a       <= 1'b1;
      vote_b       <= 1'b1;
      shreg        <= '0;
      par_q        <= 1'b0;
      frm_q        <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;

      if (state == ST_IDLE) begin
        // Holding at zero means the bit timing restarts exactly at start detection.
        div_cnt <= '0;
        smp_cnt <= '0;
        bit_cnt <= '0;
        par_q   <= 1'b0;
        frm_q   <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick)
          smp_cnt <= (smp_cnt == SMP_W'(OVERSAMPLE - 1)) ? '0 : smp_cnt + 1'b1;
        if (tick && smp_cnt == SMP_W'(M - 1)) vote_a <= rx_s;
        if (tick && smp_cnt == SMP_W'(M))     vote_b <= rx_s;

        if (state_next != state) bit_cnt <= '0;
        else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;

        if (decide && state == ST_DATA)
          shreg <= {bit_val, shreg[DATA_BITS-1:1]};
        if (decide && state == ST_PARITY)
          par_q <= bit_val ^ par_exp;
        if (decide && state == ST_STOP && !bit_val)
          frm_q <= 1'b1;
      end

      if (complete) begin
        if (!valid_o || ready_i) begin
          data_o       <= shreg;
          parity_err_o <= par_q;
          frame_err_o  <= frm_q | ~bit_val;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E2 instance at 160 clk/bit.
// Each scenario task drives the serial line and checks the received stream inline.
// A negedge monitor records accepted words, valid cycles and overrun pulses.
module tb_uart_rx_param;

  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic       ready8 = 1'b1;
  logic       ready7 = 1'b1;
  logic [7:0] data8;
  logic [6:0] data7;
  logic       valid8, pe8, fe8, ovr8, busy8;
  logic       valid7, pe7, fe7, ovr7, busy7;

  int n_checks = 0;
  int n_fail   = 0;

  int         acc8 = 0, vcyc8 = 0, ovcnt8 = 0;
  logic [7:0] last8 = '0;
  logic       lpe8 = 1'b0, lfe8 = 1'b0;
  int         acc7 = 0;
  logic [6:0] last7 = '0;
  logic       lpe7 = 1'b0, lfe7 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_HZ(1_600_000), .BIT_RATE(10_000), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u8 (
    .clk_i(clk), .reset_i(rst), .rx_i(rx8), .data_o(data8), .valid_o(valid8),
    .ready_i(ready8), .parity_err_o(pe8), .frame_err_o(fe8), .overrun_o(ovr8),
    .busy_o(busy8)
  );

  uart_rx_param #(
    .CLK_HZ(1_600_000), .BIT_RATE(10_000), .OVERSAMPLE(16),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u7 (
    .clk_i(clk), .reset_i(rst), .rx_i(rx7), .data_o(data7), .valid_o(valid7),
    .ready_i(ready7), .parity_err_o(pe7), .frame_err_o(fe7), .overrun_o(ovr7),
    .busy_o(busy7)
  );

  always @(negedge clk) begin
    if (valid8 && ready8) begin
      acc8++;
      last8 = data8;
      lpe8  = pe8;
      lfe8  = fe8;
    end
    if (valid8) vcyc8++;
    if (ovr8)   ovcnt8++;
    if (valid7 && ready7) begin
      acc7++;
      last7 = data7;
      lpe7  = pe7;
      lfe7  = fe7;
    end
  end

  task automatic drive8(input logic v, input int clks);
    rx8 = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic drive7(input logic v);
    rx7 = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d, input logic stop_v);
    drive8(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive8(d[i], BIT_CLKS);
    drive8(stop_v, BIT_CLKS);
  endtask

  task automatic send7(input logic [6:0] d, input logic par_v);
    drive7(1'b0);
    for (int i = 0; i < 7; i++) drive7(d[i]);
    drive7(par_v);
    drive7(1'b1);
    drive7(1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (valid8 !== 1'b0) begin n_fail++; $display("FAIL rst_valid8: got %b want 0", valid8); end
    n_checks++; if (data8 !== 8'h00) begin n_fail++; $display("FAIL rst_data8: got %h want 00", data8); end
    n_checks++; if ({pe8, fe8, ovr8, busy8} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags8: got %b want 0000", {pe8, fe8, ovr8, busy8}); end
    n_checks++; if ({valid7, data7, pe7, fe7, ovr7, busy7} !== 12'h000) begin n_fail++; $display("FAIL rst_all7: got %h want 000", {valid7, data7, pe7, fe7, ovr7, busy7}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if ({valid8, busy8, valid7, busy7} !== 4'b0000) begin n_fail++; $display("FAIL idle_after_rst: got %b want 0000", {valid8, busy8, valid7, busy7}); end
  endtask

  task automatic test_8n1;
    int a0, v0;
    a0 = acc8; v0 = vcyc8;
    send8(8'hA5, 1'b1);
    drive8(1'b1, 40);
    n_checks++; if (acc8 - a0 !== 1) begin n_fail++; $display("FAIL a5_count: got %0d want 1", acc8 - a0); end
    n_checks++; if (vcyc8 - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_cycles: got %0d want 1", vcyc8 - v0); end
    n_checks++; if (last8 !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", last8); end
    n_checks++; if ({lpe8, lfe8} !== 2'b00) begin n_fail++; $display("FAIL a5_flags: got %b want 00", {lpe8, lfe8}); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL a5_busy: got %b want 0", busy8); end
  endtask

  task automatic test_parity;
    int a0;
    // 0x55 over 7 bits has four ones, so the even parity bit is 0.
    a0 = acc7;
    send7(7'h55, 1'b0);
    repeat (40) @(negedge clk);
    n_checks++; if (acc7 - a0 !== 1) begin n_fail++; $display("FAIL par_ok_count: got %0d want 1", acc7 - a0); end
    n_checks++; if (last7 !== 7'h55) begin n_fail++; $display("FAIL par_ok_data: got %h want 55", last7); end
    n_checks++; if ({lpe7, lfe7} !== 2'b00) begin n_fail++; $display("FAIL par_ok_flags: got %b want 00", {lpe7, lfe7}); end
    send7(7'h55, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++; if (acc7 - a0 !== 2) begin n_fail++; $display("FAIL par_bad_count: got %0d want 2", acc7 - a0); end
    n_checks++; if (last7 !== 7'h55) begin n_fail++; $display("FAIL par_bad_data: got %h want 55", last7); end
    n_checks++; if ({lpe7, lfe7} !== 2'b10) begin n_fail++; $display("FAIL par_bad_flags: got %b want 10", {lpe7, lfe7}); end
  endtask

  task automatic test_frame_err;
    send8(8'h3C, 1'b0);
    drive8(1'b1, 2 * BIT_CLKS);
    n_checks++; if (last8 !== 8'h3C) begin n_fail++; $display("FAIL fe_data: got %h want 3c", last8); end
    n_checks++; if (lfe8 !== 1'b1) begin n_fail++; $display("FAIL fe_flag: got %b want 1", lfe8); end
    send8(8'h01, 1'b1);
    drive8(1'b1, 40);
    n_checks++; if (last8 !== 8'h01) begin n_fail++; $display("FAIL fe_next_data: got %h want 01", last8); end
    n_checks++; if (lfe8 !== 1'b0) begin n_fail++; $display("FAIL fe_next_flag: got %b want 0", lfe8); end
  endtask

  task automatic test_glitch;
    int a0;
    a0 = acc8;
    drive8(1'b0, 40);
    drive8(1'b1, 2 * BIT_CLKS);
    n_checks++; if (acc8 - a0 !== 0) begin n_fail++; $display("FAIL false_start_count: got %0d want 0", acc8 - a0); end
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL false_start_busy: got %b want 0", busy8); end
    // 0x00 with a 2-clock high glitch in the middle of data bit 3.
    drive8(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive8(1'b0, 78);
        drive8(1'b1, 2);
        drive8(1'b0, 80);
      end else begin
        drive8(1'b0, BIT_CLKS);
      end
    end
    drive8(1'b1, BIT_CLKS);
    drive8(1'b1, 40);
    n_checks++; if (acc8 - a0 !== 1) begin n_fail++; $display("FAIL glitch_count: got %0d want 1", acc8 - a0); end
    n_checks++; if (last8 !== 8'h00) begin n_fail++; $display("FAIL glitch_data: got %h want 00", last8); end
  endtask

  task automatic test_back_to_back_overrun;
    int a0, o0;
    a0 = acc8; o0 = ovcnt8;
    ready8 = 1'b0;
    send8(8'h11, 1'b1);
    send8(8'h22, 1'b1);
    drive8(1'b1, 20);
    n_checks++; if (valid8 !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", valid8); end
    n_checks++; if (data8 !== 8'h11) begin n_fail++; $display("FAIL ovr_data_held: got %h want 11", data8); end
    n_checks++; if (ovcnt8 - o0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", ovcnt8 - o0); end
    @(posedge clk);
    #1 ready8 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (acc8 - a0 !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d want 1", acc8 - a0); end
    n_checks++; if (last8 !== 8'h11) begin n_fail++; $display("FAIL ovr_accept_data: got %h want 11", last8); end
    n_checks++; if (valid8 !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b want 0", valid8); end
  endtask

  task automatic test_reset_midframe;
    int a0;
    logic [7:0] d;
    a0 = acc8;
    d = 8'h5A;
    drive8(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive8(d[i], BIT_CLKS);
    drive8(d[4], 80);
    rst = 1'b1;
    rx8 = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if ({valid8, busy8, pe8, fe8, ovr8} !== 5'b00000) begin n_fail++; $display("FAIL midrst_flags: got %b want 00000", {valid8, busy8, pe8, fe8, ovr8}); end
    n_checks++; if (data8 !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", data8); end
    rst = 1'b0;
    drive8(1'b1, 2 * BIT_CLKS);
    n_checks++; if (acc8 - a0 !== 0 || valid8 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_word: got count %0d valid %b want 0 0", acc8 - a0, valid8); end
    send8(8'h7E, 1'b1);
    drive8(1'b1, 40);
    n_checks++; if (acc8 - a0 !== 1) begin n_fail++; $display("FAIL post_rst_count: got %0d want 1", acc8 - a0); end
    n_checks++; if (last8 !== 8'h7E || {lpe8, lfe8} !== 2'b00) begin n_fail++; $display("FAIL post_rst_word: got %h/%b want 7e/00", last8, {lpe8, lfe8}); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_frame_err;
    test_glitch;
    test_back_to_back_overrun;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the fixed 8N1 receiver in the serial controller. It recovers frames of configurable width, parity and stop-bit count using oversampling with 3-sample majority vote, and flags parity, framing and overrun errors. It drives a valid/ready stream towards the register/FIFO side and free-runs on the line without any per-word arm request.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz
- BIT_RATE, 9600: line baud rate
- OVERSAMPLE, 16: ticks per bit, even, range 8..32
- DATA_BITS, 8: data bits per frame, range 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2

- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- data_o  out  DATA_BITS  received word, LSB = first data bit on line
- valid_o  out  1  data_o and error flags are valid
- ready_i  in  1  consumer accepts the word when valid_o && ready_i
- parity_err_o  out  1  parity mismatch for the word on data_o; 0 when PARITY=0
- frame_err_o  out  1  a stop bit sampled low for the word on data_o
- overrun_o  out  1  one-cycle pulse: a completed word was dropped
- busy_o  out  1  high while the FSM is not in IDLE

## Operation
- Reset values: data_o all 0, valid_o 0, all error flags 0, busy_o 0, FSM in IDLE, synchronizer flops 1.
- rx_i passes through a 2-flop synchronizer. All later logic uses the synchronized value rx_s.
- Tick generator:
  - DIV = CLK_HZ / (BIT_RATE*OVERSAMPLE), integer floor.
  - The counter runs 0..DIV-1 and asserts tick on DIV-1.
  - In IDLE the counter is held at 0. It restarts from 0 on start detection.
- Sample counter: 0..OVERSAMPLE-1, advanced on tick. Bit value = majority of rx_s at sample indices M-1, M, M+1, with M = OVERSAMPLE/2. The bit is decided at index M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge of rx_s.
  - START: at the decision point, a majority of 1 is a false start -> IDLE with no output. A majority of 0 -> DATA at the bit boundary.
  - DATA: shift DATA_BITS bits in LSB first. -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: compare the sampled bit with the expected value (odd: XOR of data bits ^ 1; even: XOR of data bits). Store the mismatch.
  - STOP: sample STOP_BITS bits. Any 0 sets frame error. At the decision point of the last stop bit, complete the word and go -> IDLE immediately. This gives half a bit of margin for resynchronization.
- Completion (one cycle):
  - If !valid_o, or valid_o && ready_i in the same cycle: load data_o and both error flags, and set valid_o=1.
  - Otherwise the new word is dropped, overrun_o pulses 1, and data_o and flags are unchanged.
- Handshake: valid_o stays high and data_o stays stable until ready_i is sampled high. ready_i without a completion clears valid_o. Error flags are only meaningful while valid_o=1.
- A frame error does not block reception. A line held low after a frame error is not re-detected as a start until rx_s returns high and falls again.
- reset_i mid-frame aborts the frame immediately. No partial word is ever presented.

## Timing
- Start detection: one cycle after the rx_s falling edge, which is 3 clk_i cycles after the rx_i edge, the counters are cleared.
- Bit decision: at tick index M+1 of each bit. The next bit window starts after tick OVERSAMPLE-1.
- valid_o rises on the clock edge following the last stop bit's decision tick. Latency from the rx_i start edge ≈ (1+DATA_BITS+P+STOP_BITS-1)*OVERSAMPLE*DIV + (M+1)*DIV + 3 cycles, where P=1 if PARITY!=0, else 0.
- Throughput: back-to-back frames with no idle gap between the stop bit and the next start bit are received with no loss, provided the consumer accepts within one frame time.
- overrun_o, parity_err_o and frame_err_o never assert while reset_i=1.

## Test plan
- Bench setup for all scenarios: CLK_HZ=1_600_000, BIT_RATE=10_000, OVERSAMPLE=16 (DIV=10, 160 clk/bit), ready_i=1 unless stated.
- 8N1, send 0xA5 -> valid_o for 1 cycle, data_o=0xA5, both error flags 0.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2. Send 0x55 with correct parity -> data_o=0x55, parity_err_o=0. Resend with the parity bit inverted -> data_o=0x55, parity_err_o=1.
- 8N1, send 0x3C with the stop bit forced low -> data_o=0x3C, frame_err_o=1. Then line high, send 0x01 -> data_o=0x01, frame_err_o=0.
- Glitches: a 40-clock low pulse on an idle line -> no valid_o, busy_o returns to 0. A 2-clock glitch in the middle of data bit 3 of 0x00 -> majority vote yields data_o=0x00.
- ready_i=0: send 0x11 then 0x22 back-to-back -> valid_o high, data_o=0x11, one overrun_o pulse at the second completion. Raise ready_i -> 0x11 accepted, then valid_o=0.
- Assert reset_i during data bit 4 of a frame, then release -> all outputs at reset values, no valid_o. The next full frame 0x7E is received correctly.
